// File: rtl/dump_input_file_if.sv
// Handshake bundle for the image dump block: the start/busy/done control,
// the 1-bit image RAM read port and the UART transmit request.
interface dump_input_file_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_q;
  logic [7:0]            tx_data;
  logic                  trmt;
  logic                  tx_done;

  modport master (
    input  start, ram_q, tx_done,
    output busy, done, ram_addr, tx_data, trmt
  );

  modport slave (
    output start, ram_q, tx_done,
    input  busy, done, ram_addr, tx_data, trmt
  );
endinterface

// File: rtl/dump_input_file.sv
// Reads a 1-bit image RAM eight addresses at a time, packs each group LSB-first
// into a byte and hands it to the UART, waiting for tx_done between bytes.
module dump_input_file #(
  parameter int NUM_BITS   = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  dump_input_file_if.master bus
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    SEND,
    WAIT,
    FIN
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       tx_data_reg;
  logic             trmt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [7:0]       byte_next;

  // New bits enter at bit 7, so after eight shifts address 8k lands in bit 0.
  assign byte_next = {bus.ram_q, shift_reg[7:1]};

  // The counter already reads zero outside a dump, so it drives the RAM directly.
  assign bus.ram_addr = ADDR_WIDTH'(cnt_reg);
  assign bus.tx_data  = tx_data_reg;
  assign bus.trmt     = trmt_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      tx_data_reg <= '0;
      trmt_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      trmt_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          // ram_q is one address behind; on the first cycle of a byte it is stale.
          if (cnt_reg[2:0] != 3'd0) begin
            shift_reg <= byte_next;
          end
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg[2:0] == 3'd7) begin
            state_reg <= LAST;
          end
        end
        LAST: begin
          shift_reg   <= byte_next;
          tx_data_reg <= byte_next;
          trmt_reg    <= 1'b1;
          state_reg   <= SEND;
        end
        SEND: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            if (cnt_reg == CNT_END) begin
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end else begin
              state_reg <= READ;
            end
          end
        end
        FIN: begin
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dump_input_file.sv
// Directed bench for dump_input_file: first-byte packing table, full dumps,
// stalled/stray handshakes, mid-dump reset and a 16-bit instance.
module tb_dump_input_file;

  localparam int AW  = 10;
  localparam int NB  = 784;
  localparam int NB2 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  dump_input_file_if #(.ADDR_WIDTH(AW)) bus ();
  dump_input_file_if #(.ADDR_WIDTH(AW)) bus2 ();

  dump_input_file #(.NUM_BITS(NB), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  dump_input_file #(.NUM_BITS(NB2), .ADDR_WIDTH(AW)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2.master)
  );

  logic mem [0:1023];

  always @(posedge clk) begin
    bus.ram_q  <= mem[bus.ram_addr];
    bus2.ram_q <= mem[bus2.ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int trmt_cnt = 0;
  int done_cnt = 0;
  int byte_idx = 0;
  int hold_idx = -1;
  int ack_cnt = 0;
  logic ack_pulse = 1'b0;
  logic stray_done = 1'b0;

  assign bus.tx_done = ack_pulse | stray_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Byte k is RAM addresses 8k..8k+7, lowest address in bit 0.
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = mem[8*k+i];
    return r;
  endfunction

  // Monitor and UART model: checks every byte, answers tx_done after 5 cycles
  // (1000 for the byte selected by hold_idx).
  always @(negedge clk) begin
    ack_pulse = 1'b0;
    if (!rst_n) begin
      ack_cnt = 0;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) ack_pulse = 1'b1;
    end
    if (bus.trmt) begin
      chk($sformatf("tx_data byte %0d", byte_idx), {24'd0, bus.tx_data}, {24'd0, exp_byte(byte_idx)});
      ack_cnt = (byte_idx == hold_idx) ? 1000 : 5;
      byte_idx++;
      trmt_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      chk("trmt_with_done", {31'd0, bus.trmt}, 32'd0);
    end
  end

  typedef struct {
    logic [0:7] bits;  // RAM addresses 0..7, left to right
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_big();
    @(negedge clk);
    byte_idx = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_trmts(input int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 20000) begin
      @(negedge clk);
      t++;
      if (bus.trmt) k++;
    end
    if (k < n) chk("trmt_timeout", k, n);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 30000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic load_alt_image();
    for (int k = 0; k < NB / 8; k++)
      for (int i = 0; i < 8; i++) mem[8*k+i] = k[0];
  endtask

  initial begin
    int lat, base_t, base_d, bad_t, bad_d, bad_a, n_t, n_d, acks, done_after, cd;
    logic [0:7] pat;

    bus.start = 1'b0;
    bus2.start = 1'b0;
    bus2.tx_done = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;

    vecs[0] = '{8'b10100101, 8'hA5};
    vecs[1] = '{8'b10000000, 8'h01};
    vecs[2] = '{8'b11000000, 8'h03};
    vecs[3] = '{8'b00001111, 8'hF0};
    vecs[4] = '{8'b10110000, 8'h0D};
    vecs[5] = '{8'b01111111, 8'hFE};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst trmt", {31'd0, bus.trmt}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst ram_addr", {22'd0, bus.ram_addr}, 32'd0);
    rst_n = 1'b1;

    // First-byte packing and latency table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      pat = vecs[v].bits;
      for (int i = 0; i < 8; i++) mem[i] = pat[i];
      start_big();
      chk($sformatf("vec%0d busy", v), {31'd0, bus.busy}, 32'd1);
      lat = 1;
      while (!bus.trmt && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("vec%0d latency", v), lat, 32'd10);
      chk($sformatf("vec%0d tx_data", v), {24'd0, bus.tx_data}, {24'd0, vecs[v].exp});
    end

    // Full alternating image, then start during FIN
    do_reset();
    load_alt_image();
    hold_idx = -1;
    base_t = trmt_cnt;
    base_d = done_cnt;
    start_big();
    wait_done();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy after done", {31'd0, bus.busy}, 32'd0);
    bad_t = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy || bus.trmt) bad_t++;
    end
    chk("start in FIN ignored", bad_t, 32'd0);
    chk("full dump bytes", trmt_cnt - base_t, 32'd98);
    chk("full dump done", done_cnt - base_d, 32'd1);

    // tx_done withheld, start and stray tx_done while busy
    do_reset();
    hold_idx = 3;
    base_t = trmt_cnt;
    base_d = done_cnt;
    start_big();
    wait_trmts(4);
    @(negedge clk);
    bad_t = 0;
    bad_d = 0;
    bad_a = 0;
    repeat (900) begin
      @(negedge clk);
      if (bus.trmt) bad_t++;
      if (bus.tx_data !== 8'hFF) bad_d++;
      if (bus.ram_addr !== 10'd32) bad_a++;
    end
    chk("stall trmt pulses", bad_t, 32'd0);
    chk("stall tx_data moved", bad_d, 32'd0);
    chk("stall ram_addr moved", bad_a, 32'd0);
    wait_trmts(37);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.ram_addr[2:0] != 3'd3 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    chk("stall dump bytes", trmt_cnt - base_t, 32'd98);
    chk("stall dump done", done_cnt - base_d, 32'd1);
    hold_idx = -1;

    // Reset during WAIT of byte 50
    do_reset();
    start_big();
    wait_trmts(51);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort trmt", {31'd0, bus.trmt}, 32'd0);
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("abort ram_addr", {22'd0, bus.ram_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base_t = trmt_cnt;
    base_d = done_cnt;
    repeat (40) @(negedge clk);
    chk("post-abort trmt", trmt_cnt - base_t, 32'd0);
    chk("post-abort done", done_cnt - base_d, 32'd0);
    pat = 8'b10100101;
    for (int i = 0; i < 8; i++) mem[i] = pat[i];
    start_big();
    chk("restart ram_addr", {22'd0, bus.ram_addr}, 32'd0);
    wait_trmts(1);
    chk("restart first byte", {24'd0, bus.tx_data}, 32'hA5);
    wait_done();
    repeat (2) @(negedge clk);
    chk("restart dump bytes", trmt_cnt - base_t, 32'd98);

    // 16-bit instance: bytes A5 then FF
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    n_t = 0;
    n_d = 0;
    acks = 0;
    done_after = -1;
    cd = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus2.tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus2.tx_done = 1'b1;
          acks++;
        end
      end
      if (bus2.trmt) begin
        chk($sformatf("small byte %0d", n_t), {24'd0, bus2.tx_data}, (n_t == 0) ? 32'hA5 : 32'hFF);
        n_t++;
        cd = 5;
      end
      if (bus2.done) begin
        n_d++;
        done_after = acks;
      end
    end
    chk("small trmt count", n_t, 32'd2);
    chk("small done count", n_d, 32'd1);
    chk("small done after acks", done_after, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dump_input_file.md
DUMP_INPUT_FILE -- requirements
Module: dump_input_file

Interface
REQ-001 Parameter NUM_BITS, default 784, meaning number of 1-bit image RAM entries to read out; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, meaning width of the RAM address bus.
REQ-003 clk  input  1  system clock, 50 MHz; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin dumping the image RAM.
REQ-006 ram_addr  output  ADDR_WIDTH  read address to the 1-bit image RAM.
REQ-007 ram_q  input  1  RAM read data; valid the cycle after ram_addr is presented (synchronous read, 1-cycle latency).
REQ-008 tx_data  output  8  packed byte presented to the UART transmitter.
REQ-009 trmt  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-010 tx_done  input  1  UART transmitter pulse indicating the previous byte has finished sending.
REQ-011 busy  output  1  high from the cycle after an accepted start until done pulses.
REQ-012 done  output  1  one-cycle pulse after the final byte's tx_done.

Function
REQ-013 FSM states SHALL be IDLE, READ, LAST, SEND, WAIT, FIN.
REQ-014 IDLE: ram_addr = 0, busy = 0; start = 1 SHALL clear bit counter and go to READ; otherwise stay.
REQ-015 READ: ram_addr SHALL equal bit counter; counter SHALL increment every cycle; after the 8th address of the byte (counter[2:0] wraps to 0), go to LAST.
REQ-016 Every cycle in READ (except the first of each byte) and in LAST, ram_q SHALL be shifted into the byte register MSB-first-in (shift right, ram_q into bit 7).
REQ-017 Packing: RAM bit at address 8k+i SHALL appear at tx_data[i] of byte k (LSB = lowest address), mirroring the loader's LSB-first write order.
REQ-018 LAST: capture the 8th bit, then go to SEND (byte latency: 9 cycles from entering READ to SEND).
REQ-019 SEND: trmt = 1 for exactly one cycle with tx_data stable; go to WAIT.
REQ-020 tx_data SHALL hold its value from SEND until the next LAST capture.
REQ-021 WAIT: on tx_done = 1, go to FIN if counter == NUM_BITS, else to READ; otherwise stay in WAIT indefinitely.
REQ-022 FIN: done = 1 for one cycle, counter cleared, go to IDLE.
REQ-023 Total bytes transmitted per start SHALL be NUM_BITS/8 (98 at default); counter SHALL never exceed NUM_BITS.
REQ-024 start asserted while busy SHALL be ignored; it SHALL NOT restart or extend the dump.
REQ-025 tx_done outside WAIT SHALL be ignored.
REQ-026 start and done in the same cycle (start during FIN) SHALL be ignored; a new dump requires start in IDLE.
REQ-027 trmt and done SHALL never be asserted in the same cycle.

Reset
REQ-028 On rst_n low, asynchronously: state = IDLE, counter = 0, byte register = 0, tx_data = 0, trmt = 0, busy = 0, done = 0, ram_addr = 0.
REQ-029 Reset mid-dump SHALL abort immediately; no further trmt or done until a new start after reset release.

Verification
REQ-030 RAM preloaded 0xA5 pattern at addresses 0-7 (bits 1,0,1,0,0,1,0,1), start -> first trmt 10 cycles after start with tx_data = 8'hA5.
REQ-031 Full image of alternating bytes 0x00/0xFF, tx_done returned 5 cycles after each trmt -> exactly 98 trmt pulses, data alternating 00/FF, one done pulse, busy low after done.
REQ-032 tx_done withheld 1000 cycles -> trmt stays low, tx_data stable, ram_addr unchanged until tx_done.
REQ-033 start pulsed during byte 40 and tx_done pulsed during READ -> byte count still 98, no extra trmt.
REQ-034 rst_n asserted during WAIT of byte 50 -> all outputs 0 same cycle; later start dumps from address 0, first byte = RAM bits 0-7.
REQ-035 NUM_BITS = 16 -> exactly 2 trmt pulses, done after second tx_done.
